// File: rtl/datapath_pkg.sv
// Shared datapath types for the dispatch stage: decoded instruction,
// FU selectors, register-status tag encodings and FUST row layouts.
package datapath_pkg;

    localparam int NUM_FUST     = 5;
    localparam int FU_ALU_IDX   = 0;
    localparam int FU_LDST_IDX  = 1;
    localparam int FU_BR_IDX    = 2;
    localparam int FU_MLDST_IDX = 3;
    localparam int FU_GEMM_IDX  = 4;

    localparam int SREG_AW = 5;
    localparam int MREG_AW = 4;
    localparam int TAG_W   = 2;

    typedef logic [SREG_AW-1:0] sreg_t;
    typedef logic [MREG_AW-1:0] mreg_t;
    typedef logic [TAG_W-1:0]   tag_t;

    typedef enum logic [1:0] {
        FU_S_T = 2'd0,
        FU_M_T = 2'd1,
        FU_G_T = 2'd2
    } fu_type_t;

    typedef enum logic [1:0] {
        FU_S_ALU    = 2'd0,
        FU_S_LDST   = 2'd1,
        FU_S_BRANCH = 2'd2
    } fu_s_t;

    // Value 3 is reserved and is never written into the scalar table.
    typedef enum logic [1:0] {
        STAG_READY = 2'd0,
        STAG_ALU   = 2'd1,
        STAG_LDST  = 2'd2,
        STAG_RSVD  = 2'd3
    } s_tag_t;

    typedef enum logic [1:0] {
        MTAG_READY = 2'd0,
        MTAG_LDST  = 2'd1,
        MTAG_GEMM  = 2'd2
    } m_tag_t;

    typedef struct packed {
        fu_type_t    fu_t;
        fu_s_t       fu_s;
        sreg_t       rd;
        sreg_t       rs1;
        sreg_t       rs2;
        mreg_t       md;
        mreg_t       ms1;
        mreg_t       ms2;
        mreg_t       ms3;
        logic [31:0] imm;
        logic        s_wen;
        logic        m_wen;
    } dispatch_in_t;

    typedef struct packed {
        sreg_t       rd;
        sreg_t       rs1;
        sreg_t       rs2;
        logic [31:0] imm;
        logic        s_wen;
        tag_t        t1;
        tag_t        t2;
    } fust_s_row_t;

    // Matrix LD/ST: t1/t2 are scalar address operands, t3 the matrix store source.
    typedef struct packed {
        mreg_t       md;
        mreg_t       ms1;
        sreg_t       rs1;
        sreg_t       rs2;
        logic [31:0] imm;
        logic        m_wen;
        tag_t        t1;
        tag_t        t2;
        tag_t        t3;
    } fust_m_row_t;

    typedef struct packed {
        mreg_t md;
        mreg_t ms1;
        mreg_t ms2;
        mreg_t ms3;
        logic  m_wen;
        tag_t  t1;
        tag_t  t2;
        tag_t  t3;
    } fust_g_row_t;

endpackage

// File: rtl/dispatch_if.sv
// Decoded-instruction handshake between decode (master) and dispatch (slave).
interface dispatch_if;
    import datapath_pkg::*;

    logic         in_valid;
    logic         in_ready;
    dispatch_in_t in_instr;

    modport master (output in_valid, output in_instr, input in_ready);
    modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/dispatch_reg_status_table.sv
// Register status table: per-register producer tag, combinational read ports
// with writeback bypass, one set port and one tag-qualified clear port.
module reg_status_table #(
    parameter int  NUM_REGS = 32,
    parameter int  TAG_W    = 2,
    parameter int  NUM_RD   = 3,
    parameter bit  ZERO_REG = 1'b0,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
    output logic [NUM_RD-1:0][TAG_W-1:0] rd_tag,
    input  logic                         set_en,
    input  logic [AW-1:0]                set_addr,
    input  logic [TAG_W-1:0]             set_tag,
    input  logic                         clr_en,
    input  logic [AW-1:0]                clr_addr,
    input  logic [TAG_W-1:0]             clr_tag
);

    logic [TAG_W-1:0] tags [NUM_REGS];
    logic             clr_hit;

    assign clr_hit = clr_en && (tags[clr_addr] == clr_tag);

    // Set is applied after clear so a same-cycle dispatch write wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tags[i] <= '0;
            end
        end else begin
            if (clr_hit) begin
                tags[clr_addr] <= '0;
            end
            if (set_en && !(ZERO_REG && (set_addr == '0))) begin
                tags[set_addr] <= set_tag;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_tag[i] = tags[rd_addr[i]];
            if (clr_hit && (clr_addr == rd_addr[i])) begin
                rd_tag[i] = '0;
            end
            if (ZERO_REG && (rd_addr[i] == '0)) begin
                rd_tag[i] = '0;
            end
        end
    end

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: single-entry hold register, scalar/matrix tag tracking and
// one FUST row write per dispatched instruction.
module dispatch
    import datapath_pkg::*;
#(
    parameter int NUM_SREG = 32,
    parameter int NUM_MREG = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    dispatch_if.slave           in_if,
    input  logic                freeze,
    input  logic                flush,
    input  logic [NUM_FUST-1:0] fust_busy,
    input  logic                wb_s_en,
    input  sreg_t               wb_s_rd,
    input  tag_t                wb_s_tag,
    input  logic                wb_m_en,
    input  mreg_t               wb_m_md,
    input  tag_t                wb_m_tag,
    output logic                n_fust_s_en,
    output fu_s_t               n_fu_s,
    output fust_s_row_t         n_fust_s,
    output logic                n_fust_m_en,
    output fust_m_row_t         n_fust_m,
    output logic                n_fust_g_en,
    output fust_g_row_t         n_fust_g
);

    logic             held_valid;
    dispatch_in_t     held;
    logic             in_ready;
    logic             dispatching;
    logic             target_busy;
    logic             waw;
    logic             s_set_en;
    tag_t             s_set_tag;
    logic             m_set_en;
    tag_t             m_set_tag;
    logic [2:0][SREG_AW-1:0] s_rd_addr;
    logic [2:0][TAG_W-1:0]   s_tags;
    logic [3:0][MREG_AW-1:0] m_rd_addr;
    logic [3:0][TAG_W-1:0]   m_tags;

    // in_ready is gated by nRST since held_valid alone reads as empty in reset.
    assign in_ready       = nRST && !freeze && (!held_valid || dispatching);
    assign in_if.in_ready = in_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (!freeze) begin
            if (in_if.in_valid && in_ready) begin
                held_valid <= 1'b1;
                held       <= in_if.in_instr;
            end else if (dispatching) begin
                held_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        target_busy = fust_busy[FU_GEMM_IDX];
        case (held.fu_t)
            FU_S_T: begin
                case (held.fu_s)
                    FU_S_ALU:    target_busy = fust_busy[FU_ALU_IDX];
                    FU_S_LDST:   target_busy = fust_busy[FU_LDST_IDX];
                    default:     target_busy = fust_busy[FU_BR_IDX];
                endcase
            end
            FU_M_T:  target_busy = fust_busy[FU_MLDST_IDX];
            default: target_busy = fust_busy[FU_GEMM_IDX];
        endcase
    end

    assign s_rd_addr[0] = held.rs1;
    assign s_rd_addr[1] = held.rs2;
    assign s_rd_addr[2] = held.rd;
    assign m_rd_addr[0] = held.ms1;
    assign m_rd_addr[1] = held.ms2;
    assign m_rd_addr[2] = held.ms3;
    assign m_rd_addr[3] = held.md;

    assign waw = (held.s_wen && (s_tags[2] != '0)) ||
                 (held.m_wen && (m_tags[3] != '0));

    assign dispatching = held_valid && !freeze && !flush && !target_busy && !waw;

    // Branches have no scalar tag encoding, so only ALU and LD/ST claim rd.
    assign s_set_en  = dispatching && held.s_wen && (held.rd != '0) &&
                       (held.fu_t == FU_S_T) && (held.fu_s != FU_S_BRANCH);
    assign s_set_tag = (held.fu_s == FU_S_LDST) ? STAG_LDST : STAG_ALU;
    assign m_set_en  = dispatching && held.m_wen && (held.fu_t != FU_S_T);
    assign m_set_tag = (held.fu_t == FU_G_T) ? MTAG_GEMM : MTAG_LDST;

    reg_status_table #(
        .NUM_REGS (NUM_SREG),
        .TAG_W    (TAG_W),
        .NUM_RD   (3),
        .ZERO_REG (1'b1)
    ) u_s_table (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_addr  (s_rd_addr),
        .rd_tag   (s_tags),
        .set_en   (s_set_en),
        .set_addr (held.rd),
        .set_tag  (s_set_tag),
        .clr_en   (wb_s_en),
        .clr_addr (wb_s_rd),
        .clr_tag  (wb_s_tag)
    );

    reg_status_table #(
        .NUM_REGS (NUM_MREG),
        .TAG_W    (TAG_W),
        .NUM_RD   (4),
        .ZERO_REG (1'b0)
    ) u_m_table (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_addr  (m_rd_addr),
        .rd_tag   (m_tags),
        .set_en   (m_set_en),
        .set_addr (held.md),
        .set_tag  (m_set_tag),
        .clr_en   (wb_m_en),
        .clr_addr (wb_m_md),
        .clr_tag  (wb_m_tag)
    );

    always_comb begin
        n_fust_s_en = dispatching && (held.fu_t == FU_S_T);
        n_fust_m_en = dispatching && (held.fu_t == FU_M_T);
        n_fust_g_en = dispatching && (held.fu_t == FU_G_T);
        n_fu_s      = held.fu_s;

        n_fust_s       = '0;
        n_fust_s.rd    = held.rd;
        n_fust_s.rs1   = held.rs1;
        n_fust_s.rs2   = held.rs2;
        n_fust_s.imm   = held.imm;
        n_fust_s.s_wen = held.s_wen;
        n_fust_s.t1    = s_tags[0];
        n_fust_s.t2    = s_tags[1];

        n_fust_m       = '0;
        n_fust_m.md    = held.md;
        n_fust_m.ms1   = held.ms1;
        n_fust_m.rs1   = held.rs1;
        n_fust_m.rs2   = held.rs2;
        n_fust_m.imm   = held.imm;
        n_fust_m.m_wen = held.m_wen;
        n_fust_m.t1    = s_tags[0];
        n_fust_m.t2    = s_tags[1];
        n_fust_m.t3    = m_tags[0];

        n_fust_g       = '0;
        n_fust_g.md    = held.md;
        n_fust_g.ms1   = held.ms1;
        n_fust_g.ms2   = held.ms2;
        n_fust_g.ms3   = held.ms3;
        n_fust_g.m_wen = held.m_wen;
        n_fust_g.t1    = m_tags[0];
        n_fust_g.t2    = m_tags[1];
        n_fust_g.t3    = m_tags[2];
    end

endmodule

// File: tb/tb_dispatch.sv
// Scoreboard testbench for dispatch: expected FUST rows are queued when an
// instruction is offered and checked when the matching enable pulses.
module tb_dispatch;
    import datapath_pkg::*;

    typedef struct {
        int    kind;
        fu_s_t fu_s;
        sreg_t rd;
        mreg_t md;
        tag_t  t1;
        tag_t  t2;
        tag_t  t3;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        freeze, flush;
    logic [4:0]  fust_busy;
    logic        wb_s_en, wb_m_en;
    sreg_t       wb_s_rd;
    mreg_t       wb_m_md;
    tag_t        wb_s_tag, wb_m_tag;
    logic        n_fust_s_en, n_fust_m_en, n_fust_g_en;
    fu_s_t       n_fu_s;
    fust_s_row_t n_fust_s;
    fust_m_row_t n_fust_m;
    fust_g_row_t n_fust_g;

    exp_t sbQ[$];
    int   asserts = 0;
    int   failures = 0;
    int   cycleCnt = 0;
    int   dispCount = 0;
    int   lastDispCycle = 0;
    int   lastAcceptCycle = 0;
    int   savedCount;

    dispatch_if bus ();

    always #5 CLK = ~CLK;

    dispatch #(
        .NUM_SREG (32),
        .NUM_MREG (16)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .in_if       (bus),
        .freeze      (freeze),
        .flush       (flush),
        .fust_busy   (fust_busy),
        .wb_s_en     (wb_s_en),
        .wb_s_rd     (wb_s_rd),
        .wb_s_tag    (wb_s_tag),
        .wb_m_en     (wb_m_en),
        .wb_m_md     (wb_m_md),
        .wb_m_tag    (wb_m_tag),
        .n_fust_s_en (n_fust_s_en),
        .n_fu_s      (n_fu_s),
        .n_fust_s    (n_fust_s),
        .n_fust_m_en (n_fust_m_en),
        .n_fust_m    (n_fust_m),
        .n_fust_g_en (n_fust_g_en),
        .n_fust_g    (n_fust_g)
    );

    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic dispatch_in_t mk(input fu_type_t ft, input fu_s_t fs,
                                        input int rd, input int rs1, input int rs2,
                                        input int md, input int ms1, input int ms2, input int ms3,
                                        input bit sw, input bit mw);
        dispatch_in_t r;
        r.fu_t  = ft;
        r.fu_s  = fs;
        r.rd    = 5'(rd);
        r.rs1   = 5'(rs1);
        r.rs2   = 5'(rs2);
        r.md    = 4'(md);
        r.ms1   = 4'(ms1);
        r.ms2   = 4'(ms2);
        r.ms3   = 4'(ms3);
        r.imm   = 32'h100 + 32'(rd);
        r.s_wen = sw;
        r.m_wen = mw;
        return r;
    endfunction

    // Scoreboard monitor: pops one expectation per enable pulse.
    always @(negedge CLK) begin
        exp_t e;
        if (n_fust_s_en || n_fust_m_en || n_fust_g_en) begin
            checkOutput("one_hot_en", 32'(n_fust_s_en) + 32'(n_fust_m_en) + 32'(n_fust_g_en), 32'd1);
            dispCount++;
            lastDispCycle = cycleCnt;
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_en", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                if (e.kind == 0) begin
                    checkOutput("s_en", 32'(n_fust_s_en), 32'd1);
                    checkOutput("s_fu", 32'(n_fu_s), 32'(e.fu_s));
                    checkOutput("s_rd", 32'(n_fust_s.rd), 32'(e.rd));
                    checkOutput("s_t1", 32'(n_fust_s.t1), 32'(e.t1));
                    checkOutput("s_t2", 32'(n_fust_s.t2), 32'(e.t2));
                end else if (e.kind == 1) begin
                    checkOutput("m_en", 32'(n_fust_m_en), 32'd1);
                    checkOutput("m_md", 32'(n_fust_m.md), 32'(e.md));
                    checkOutput("m_t1", 32'(n_fust_m.t1), 32'(e.t1));
                    checkOutput("m_t2", 32'(n_fust_m.t2), 32'(e.t2));
                    checkOutput("m_t3", 32'(n_fust_m.t3), 32'(e.t3));
                end else begin
                    checkOutput("g_en", 32'(n_fust_g_en), 32'd1);
                    checkOutput("g_md", 32'(n_fust_g.md), 32'(e.md));
                    checkOutput("g_t1", 32'(n_fust_g.t1), 32'(e.t1));
                    checkOutput("g_t2", 32'(n_fust_g.t2), 32'(e.t2));
                    checkOutput("g_t3", 32'(n_fust_g.t3), 32'(e.t3));
                end
            end
        end
    end

    // Called 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic applyStimulus(input dispatch_in_t ins, input bit push, input int kind,
                                 input int t1, input int t2, input int t3);
        exp_t e;
        bit   accepted;
        if (push) begin
            e.kind = kind;
            e.fu_s = ins.fu_s;
            e.rd   = ins.rd;
            e.md   = ins.md;
            e.t1   = 2'(t1);
            e.t2   = 2'(t2);
            e.t3   = 2'(t3);
            sbQ.push_back(e);
        end
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                accepted = 1'b1;
                lastAcceptCycle = cycleCnt;
            end
            @(posedge CLK);
        end
        #1;
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            if (push) void'(sbQ.pop_back());
        end
    endtask

    task automatic waitDrain(input string tag, input int limit);
        for (int i = 0; i < limit && sbQ.size() != 0; i++) begin
            @(posedge CLK);
            #1;
        end
        checkOutput(tag, 32'(sbQ.size()), 32'd0);
    endtask

    task automatic pulseWbS(input int rd, input int tag);
        wb_s_en  = 1'b1;
        wb_s_rd  = 5'(rd);
        wb_s_tag = 2'(tag);
        @(posedge CLK);
        #1;
        wb_s_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        freeze = 1'b0; flush = 1'b0; fust_busy = '0;
        wb_s_en = 1'b0; wb_s_rd = '0; wb_s_tag = '0;
        wb_m_en = 1'b0; wb_m_md = '0; wb_m_tag = '0;
        bus.in_valid = 1'b0; bus.in_instr = '0;

        $display("[TB] reset");
        repeat (2) begin
            @(negedge CLK);
            checkOutput("rst_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("rst_en", 32'({n_fust_s_en, n_fust_m_en, n_fust_g_en}), 32'd0);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        checkOutput("post_rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge CLK); #1;

        $display("[TB] test 1: ALU rd=5 latency");
        applyStimulus(mk(FU_S_T, FU_S_ALU, 5, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0);
        @(negedge CLK); #1;
        checkOutput("t1_latency", 32'(lastDispCycle - lastAcceptCycle), 32'd1);
        @(posedge CLK); #1;

        $display("[TB] test 2: RAW tag and writeback bypass");
        applyStimulus(mk(FU_S_T, FU_S_LDST, 6, 5, 0, 0, 0, 0, 0, 1, 0), 1, 0, 1, 0, 0);
        waitDrain("t2_ld_drain", 10);
        applyStimulus(mk(FU_S_T, FU_S_ALU, 8, 5, 6, 0, 0, 0, 0, 1, 0), 1, 0, 0, 2, 0);
        pulseWbS(5, 1);
        checkOutput("t2_bypass_cycle", 32'(lastDispCycle - lastAcceptCycle), 32'd1);
        applyStimulus(mk(FU_S_T, FU_S_ALU, 0, 5, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        waitDrain("t2_drain", 10);

        $display("[TB] test 3: busy FUST stall");
        fust_busy = 5'b00001;
        applyStimulus(mk(FU_S_T, FU_S_ALU, 9, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("busy_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("busy_no_en", 32'(n_fust_s_en), 32'd0);
        end
        @(posedge CLK); #1;
        fust_busy = '0;
        @(negedge CLK);
        checkOutput("busy_release_en", 32'(n_fust_s_en), 32'd1);
        @(posedge CLK); #1;
        waitDrain("t3_drain", 10);

        $display("[TB] test 4: WAW stall and stale writeback");
        applyStimulus(mk(FU_S_T, FU_S_LDST, 7, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0);
        applyStimulus(mk(FU_S_T, FU_S_ALU, 7, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("waw_no_en", 32'(n_fust_s_en), 32'd0);
            checkOutput("waw_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge CLK); #1;
        wb_s_en = 1'b1; wb_s_rd = 5'd7; wb_s_tag = 2'd1;
        @(negedge CLK);
        checkOutput("stale_wb_stall", 32'(n_fust_s_en), 32'd0);
        @(posedge CLK); #1;
        wb_s_tag = 2'd2;
        @(negedge CLK);
        checkOutput("waw_release_en", 32'(n_fust_s_en), 32'd1);
        @(posedge CLK); #1;
        wb_s_en = 1'b0;
        applyStimulus(mk(FU_S_T, FU_S_ALU, 0, 7, 0, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0);
        waitDrain("t4_drain", 10);

        $display("[TB] test 5: GEMM after matrix load, with freeze");
        applyStimulus(mk(FU_M_T, FU_S_ALU, 0, 0, 0, 3, 0, 0, 0, 0, 1), 1, 1, 0, 0, 0);
        waitDrain("t5_mld_drain", 10);
        applyStimulus(mk(FU_G_T, FU_S_ALU, 0, 0, 0, 6, 3, 1, 2, 0, 1), 1, 2, 1, 0, 0);
        freeze = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            checkOutput("freeze_no_en", 32'(n_fust_g_en), 32'd0);
            checkOutput("freeze_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge CLK); #1;
        freeze = 1'b0;
        @(negedge CLK);
        checkOutput("unfreeze_g_en", 32'(n_fust_g_en), 32'd1);
        @(posedge CLK); #1;
        waitDrain("t5_drain", 10);

        $display("[TB] test 6: flush and reset mid-stall");
        fust_busy = 5'b00001;
        applyStimulus(mk(FU_S_T, FU_S_ALU, 10, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge CLK);
        checkOutput("flush_no_en", 32'(n_fust_s_en), 32'd0);
        @(posedge CLK); #1;
        flush = 1'b0;
        fust_busy = '0;
        savedCount = dispCount;
        @(negedge CLK);
        checkOutput("flush_cleared_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("flush_no_dispatch", 32'(dispCount), 32'(savedCount));
        applyStimulus(mk(FU_S_T, FU_S_ALU, 0, 8, 10, 0, 0, 0, 0, 0, 0), 1, 0, 1, 0, 0);
        waitDrain("t6_flush_drain", 10);

        fust_busy = 5'b00001;
        applyStimulus(mk(FU_S_T, FU_S_ALU, 12, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0);
        #3;
        nRST = 1'b0;
        #1;
        checkOutput("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_mid_en", 32'({n_fust_s_en, n_fust_m_en, n_fust_g_en}), 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        fust_busy = '0;
        savedCount = dispCount;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rst_held_lost", 32'(dispCount), 32'(savedCount));
        applyStimulus(mk(FU_S_T, FU_S_ALU, 0, 8, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0);
        waitDrain("t6_rst_drain", 10);

        checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
